// File: rtl/cfi_pkg.sv
// Shared control-flow-integrity types, marker constants and instruction classifiers,
// used by the call-pad checker and the return checker.
package cfi_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned REG_W = 6;

    // Local stand-ins for the core's fu_op / exception / scoreboard types
    typedef enum logic [3:0] {
        ADD, SUB, XORL, JAL, JALR, BEQ, LD, SD
    } fu_op_e;

    localparam logic [XLEN-1:0] BREAKPOINT = XLEN'(3);

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        fu_op_e           op;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  result;
        exception_t       ex;
    } scoreboard_entry_t;

    typedef enum logic {IDLE, WAIT_PAD} cfi_state_e;

    localparam fu_op_e     DEF_PAD_OP  = ADD;
    localparam logic [4:0] DEF_PAD_RD  = 5'd0;
    localparam logic [4:0] DEF_PAD_RS1 = 5'd0;
    localparam logic [11:0] DEF_PAD_IMM = 12'd2;

    localparam fu_op_e     DEF_RET_OP  = ADD;
    localparam logic [4:0] DEF_RET_RD  = 5'd0;
    localparam logic [4:0] DEF_RET_RS1 = 5'd0;
    localparam logic [11:0] DEF_RET_IMM = 12'd1;

    function automatic logic is_link(logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic logic is_call(scoreboard_entry_t e);
        return ((e.op == JAL) || (e.op == JALR)) && is_link(e.rd[4:0]) && !e.ex.valid;
    endfunction

    function automatic logic is_pad(scoreboard_entry_t e, fu_op_e op, logic [4:0] rd,
                                    logic [4:0] rs1, logic [11:0] imm);
        return (e.op == op) && (e.rd[4:0] == rd) && (e.rs1[4:0] == rs1) &&
               (e.result[11:0] == imm) && !e.ex.valid;
    endfunction

    // Function return: jalr x0, 0(ra|t0)
    function automatic logic is_ret(scoreboard_entry_t e);
        return (e.op == JALR) && (e.rd[4:0] == 5'd0) && is_link(e.rs1[4:0]) && !e.ex.valid;
    endfunction

endpackage

// File: rtl/cfi_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module cfi_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/call_pad_checker_commit.sv
// Forward-edge CFI checker: the first instruction committed after a call must be the landing pad.
// Build option CALL_PAD_CSR_EN: gate exceptions and violation counting with csr_en_i.
module call_pad_checker_commit
    import cfi_pkg::*;
#(
    parameter fu_op_e      PAD_OP          = DEF_PAD_OP,
    parameter logic [4:0]  PAD_RD          = DEF_PAD_RD,
    parameter logic [4:0]  PAD_RS1         = DEF_PAD_RS1,
    parameter logic [11:0] PAD_IMM         = DEF_PAD_IMM,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       csr_en_i,
    input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
    input  scoreboard_entry_t          commit_instr_i [NR_COMMIT_PORTS],
    output exception_t                 exception_o,
    output logic [CNT_W-1:0]           violation_cnt_o,
    output logic [CNT_W-1:0]           check_cnt_o
);

    cfi_state_e        state_q, state_d;
    exception_t        exc_q, exc_d;
    logic              do_check_c;
    logic              pad_ok_c;
    logic [XLEN-1:0]   chk_pc_c;
    logic              enforce_c;
    logic              raise_c;
    scoreboard_entry_t i0, i1;

    assign i0 = commit_instr_i[0];
    assign i1 = commit_instr_i[1];

`ifdef CALL_PAD_CSR_EN
    assign enforce_c = csr_en_i;
`else
    logic unused_csr_en;
    assign unused_csr_en = csr_en_i;
    assign enforce_c     = 1'b1;
`endif

    // Only a few fields of each entry feed the classifiers
    logic unused_instr;
    assign unused_instr = ^{i0, i1};

    // Next state and the (at most one) pad check of this cycle
    always_comb begin
        state_d    = state_q;
        do_check_c = 1'b0;
        pad_ok_c   = 1'b1;
        chk_pc_c   = '0;
        case (state_q)
            IDLE: begin
                if (commit_ack_i[0] && is_call(i0)) begin
                    if (commit_ack_i[1]) begin
                        do_check_c = 1'b1;
                        pad_ok_c   = is_pad(i1, PAD_OP, PAD_RD, PAD_RS1, PAD_IMM);
                        chk_pc_c   = i1.pc;
                        if (is_call(i1)) state_d = WAIT_PAD;
                    end else begin
                        state_d = WAIT_PAD;
                    end
                end else if (commit_ack_i[1] && is_call(i1)) begin
                    state_d = WAIT_PAD;
                end
            end
            WAIT_PAD: begin
                if (commit_ack_i[0]) begin
                    do_check_c = 1'b1;
                    pad_ok_c   = is_pad(i0, PAD_OP, PAD_RD, PAD_RS1, PAD_IMM);
                    chk_pc_c   = i0.pc;
                    state_d    = IDLE;
                    // A call right behind a good pad arms the next check
                    if (pad_ok_c && commit_ack_i[1] && is_call(i1)) state_d = WAIT_PAD;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign raise_c = do_check_c && !pad_ok_c && enforce_c;

    always_comb begin
        exc_d = '0;
        if (raise_c) begin
            exc_d.valid = 1'b1;
            exc_d.cause = BREAKPOINT;
            exc_d.tval  = chk_pc_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            exc_q   <= '0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
        end
    end

    assign exception_o = exc_q;

    cfi_sat_counter #(.W(CNT_W)) u_check_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (do_check_c),
        .cnt_o (check_cnt_o)
    );

    cfi_sat_counter #(.W(CNT_W)) u_viol_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (raise_c),
        .cnt_o (violation_cnt_o)
    );

endmodule
